// File: rtl/sram_pkg.sv
// Shared types and timing defaults for the SRAM column access sequencer.
package sram_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_ACT,
      ST_SENSE,
      ST_RECOVER
   } state_t;

   localparam int DEF_ROWS    = 16;
   localparam int DEF_COLS    = 8;
   localparam int DEF_AW      = 4;
   localparam int DEF_PRE_CYC = 1;
   localparam int DEF_WL_CYC  = 2;

   // One phase counter serves both PRE and ACT, so size it for the longer phase.
   function automatic int cnt_width(input int a, input int b);
      return $clog2((a > b) ? a : b) + 1;
   endfunction

endpackage

// File: rtl/sram_array_sequencer_if.sv
// Digital request/response port of the array sequencer.
interface sram_array_sequencer_if #(
   parameter int AW   = 4,
   parameter int COLS = 8
);
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [AW-1:0]   req_addr;
   logic [COLS-1:0] req_wdata;
   logic            rsp_valid;
   logic [COLS-1:0] rsp_rdata;
   logic            rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/sram_row_decoder.sv
// Row address to one-hot wordline decode with out-of-range detection.
module sram_row_decoder #(
   parameter int ROWS = 16,
   parameter int AW   = 4
) (
   input  logic [AW-1:0]   addr,
   input  logic            en,
   output logic [ROWS-1:0] wl,
   output logic            in_range
);

   assign in_range = (int'(addr) < ROWS);

   // An out-of-range address matches no row, so wl stays zero for it.
   for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      assign wl[gi] = en && (int'(addr) == gi);
   end

endmodule

// File: rtl/sram_array_sequencer.sv
// Sequences precharge, wordline, write drivers and sense strobe for one row access.
module sram_array_sequencer
   import sram_pkg::*;
#(
   parameter int ROWS    = DEF_ROWS,
   parameter int COLS    = DEF_COLS,
   parameter int AW      = DEF_AW,
   parameter int PRE_CYC = DEF_PRE_CYC,
   parameter int WL_CYC  = DEF_WL_CYC
) (
   input  logic                  clk,
   input  logic                  rst,
   sram_array_sequencer_if.slave bus,
   output logic [ROWS-1:0]       wl,
   output logic                  pre_en,
   output logic                  wr_en,
   output logic [COLS-1:0]       bl_drv,
   output logic [COLS-1:0]       blb_drv,
   output logic                  sa_en,
   input  logic [COLS-1:0]       sa_out
);

   localparam int CW = cnt_width(PRE_CYC, WL_CYC);

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic            we_reg;
   logic [AW-1:0]   addr_reg;
   logic [COLS-1:0] wdata_reg;
   logic [COLS-1:0] rdata_reg;
   logic            err_reg;
   logic            accept;
   logic            wl_on;
   logic            in_range;

   assign accept = (state_reg == ST_IDLE) && bus.req_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         rdata_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            we_reg    <= bus.req_we;
            addr_reg  <= bus.req_addr;
            wdata_reg <= bus.req_wdata;
         end
         // Response fields change only on entry to RECOVER and hold afterwards.
         if (state_next == ST_RECOVER) begin
            rdata_reg <= (state_reg == ST_SENSE && in_range) ? sa_out : '0;
            err_reg   <= !in_range;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (bus.req_valid) begin
               state_next = ST_PRE;
               cnt_next   = '0;
            end
         end
         ST_PRE: begin
            if (cnt_reg == CW'(PRE_CYC - 1)) begin
               state_next = ST_ACT;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         ST_ACT: begin
            if (cnt_reg == CW'(WL_CYC - 1)) begin
               state_next = we_reg ? ST_RECOVER : ST_SENSE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         ST_SENSE:   state_next = ST_RECOVER;
         ST_RECOVER: state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // Wordline stays up through SENSE so the sense amp sees a developed bitline.
   assign wl_on = (state_reg == ST_ACT) || (state_reg == ST_SENSE);

   sram_row_decoder #(
      .ROWS (ROWS),
      .AW   (AW)
   ) u_dec (
      .addr     (addr_reg),
      .en       (wl_on),
      .wl       (wl),
      .in_range (in_range)
   );

   assign wr_en   = (state_reg == ST_ACT) && we_reg && in_range;
   assign bl_drv  = wr_en ? wdata_reg : '0;
   assign blb_drv = wr_en ? ~wdata_reg : '0;
   assign sa_en   = (state_reg == ST_SENSE);
   assign pre_en  = (state_reg == ST_IDLE) || (state_reg == ST_PRE) ||
                    (state_reg == ST_RECOVER);

   assign bus.req_ready = (state_reg == ST_IDLE);
   assign bus.rsp_valid = (state_reg == ST_RECOVER);
   assign bus.rsp_rdata = rdata_reg;
   assign bus.rsp_err   = err_reg;

endmodule
